// File: rtl/adder_routine_initiator_pkg.sv
// Shared definitions for the adder routine initiator: FSM state encoding and
// default widths (also used by the adder control-register map).
package adder_routine_initiator_pkg;

  localparam int unsigned BATCH_W_DEF   = 8;
  localparam int unsigned TIMEOUT_W_DEF = 16;
  localparam int unsigned STATE_W       = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_FLUSH_GAP = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_FIN  = 3'd4,
    ST_ACK       = 3'd5,
    ST_GAP       = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

endpackage

// File: rtl/adder_initiator_timer.sv
// Per-routine wait timer: saturating up-counter with an expiry compare.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : force count to zero (has priority over enable_i)
//   enable_i      : count one cycle
//   limit_i       : expiry limit; zero means never expire
//   count_o       : current count (registered)
//   expired_c_o   : count has reached limit_i-1 (combinational compare)
module adder_initiator_timer #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic [TIMEOUT_W-1:0] limit_i,
  output logic [TIMEOUT_W-1:0] count_o,
  output logic                 expired_c_o
);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  // Count register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  // Saturate at all-ones so a disabled timeout never wraps
  always_comb begin
    count_d = count_q;
    if (clear_i)                        count_d = '0;
    else if (enable_i && count_q != '1) count_d = count_q + TIMEOUT_W'(1);
  end

  assign count_o     = count_q;
  assign expired_c_o = (limit_i != '0) && (count_q == limit_i - TIMEOUT_W'(1));

endmodule

// File: rtl/adder_routine_initiator.sv
// Host-side initiator for the adder routine handshake. Runs a batch of
// routines: start pulse, wait for finished, Ok acknowledge, wait for finished
// to drop. Flushes a stale finished before the first start, supports a
// per-routine timeout and a graceful abort.
//   Cmd_Valid/Cmd_Batch/Cmd_Ready : command accept (IDLE only)
//   Cmd_Abort                     : request stop after the in-flight routine
//   Timeout_Limit                 : max wait cycles per routine, 0 = disabled
//   Start_Routine / Finished / Ok : adder handshake
//   Busy, Done, Error_Timeout, Aborted, Routines_Completed : status
module adder_routine_initiator
  import adder_routine_initiator_pkg::*;
#(
  parameter int unsigned BATCH_W   = BATCH_W_DEF,
  parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                 ADDER_INITIATOR_Clk,
  input  logic                 ADDER_INITIATOR_Reset_InLow,
  input  logic                 ADDER_INITIATOR_Cmd_Valid,
  input  logic [BATCH_W-1:0]   ADDER_INITIATOR_Cmd_Batch,
  input  logic                 ADDER_INITIATOR_Cmd_Abort,
  input  logic [TIMEOUT_W-1:0] ADDER_INITIATOR_Timeout_Limit,
  input  logic                 ADDER_INITIATOR_Routine_Finished_Already,
  output logic                 ADDER_INITIATOR_Cmd_Ready,
  output logic                 ADDER_INITIATOR_Start_Routine,
  output logic                 ADDER_INITIATOR_Routine_Finished_Already_Ok,
  output logic                 ADDER_INITIATOR_Busy,
  output logic                 ADDER_INITIATOR_Done,
  output logic                 ADDER_INITIATOR_Error_Timeout,
  output logic                 ADDER_INITIATOR_Aborted,
  output logic [BATCH_W-1:0]   ADDER_INITIATOR_Routines_Completed
);

  state_e               state_q, state_d;
  logic [BATCH_W-1:0]   batch_q, batch_d;
  logic [BATCH_W-1:0]   completed_q, completed_d;
  logic                 err_q, err_d;
  logic                 aborted_q, aborted_d;
  logic                 abort_flag_q, abort_flag_d;
  logic                 ready_q, ready_d;
  logic                 start_q, start_d;
  logic                 ok_q, ok_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 fin;
  logic                 timer_expired;
  logic [TIMEOUT_W-1:0] timer_count_unused;

  assign fin = ADDER_INITIATOR_Routine_Finished_Already;

  // Timer is zeroed in START so the first WAIT_FIN cycle sees count 0
  adder_initiator_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk_i       (ADDER_INITIATOR_Clk),
    .rst_ni      (ADDER_INITIATOR_Reset_InLow),
    .clear_i     (state_q == ST_START),
    .enable_i    (state_q == ST_WAIT_FIN),
    .limit_i     (ADDER_INITIATOR_Timeout_Limit),
    .count_o     (timer_count_unused),
    .expired_c_o (timer_expired)
  );

  // State and output registers
  always_ff @(posedge ADDER_INITIATOR_Clk) begin
    if (!ADDER_INITIATOR_Reset_InLow) begin
      state_q      <= ST_IDLE;
      batch_q      <= '0;
      completed_q  <= '0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      abort_flag_q <= 1'b0;
      ready_q      <= 1'b1;
      start_q      <= 1'b0;
      ok_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      batch_q      <= batch_d;
      completed_q  <= completed_d;
      err_q        <= err_d;
      aborted_q    <= aborted_d;
      abort_flag_q <= abort_flag_d;
      ready_q      <= ready_d;
      start_q      <= start_d;
      ok_q         <= ok_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    batch_d      = batch_q;
    completed_d  = completed_q;
    err_d        = err_q;
    aborted_d    = aborted_q;
    abort_flag_d = abort_flag_q;

    // Abort is only latched once a batch is actually running
    if (ADDER_INITIATOR_Cmd_Abort &&
        (state_q == ST_START || state_q == ST_WAIT_FIN ||
         state_q == ST_ACK   || state_q == ST_GAP)) begin
      abort_flag_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ADDER_INITIATOR_Cmd_Valid) begin
          batch_d      = ADDER_INITIATOR_Cmd_Batch;
          completed_d  = '0;
          err_d        = 1'b0;
          aborted_d    = 1'b0;
          abort_flag_d = 1'b0;
          if (ADDER_INITIATOR_Cmd_Batch == '0) state_d = ST_DONE;
          else if (fin)                        state_d = ST_FLUSH;
          else                                 state_d = ST_START;
        end
      end
      ST_FLUSH:     state_d = ST_FLUSH_GAP;
      ST_FLUSH_GAP: if (!fin) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_FIN;
      ST_WAIT_FIN: begin
        // Finished wins over a same-cycle timeout
        if (fin) begin
          state_d = ST_ACK;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_ACK: begin
        completed_d = completed_q + BATCH_W'(1);
        state_d     = ST_GAP;
      end
      ST_GAP: begin
        if (!fin) begin
          if (completed_q == batch_q || abort_flag_d) state_d = ST_DONE;
          else                                        state_d = ST_START;
        end
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE && state_q != ST_DONE && abort_flag_d) aborted_d = 1'b1;

    ready_d = (state_d == ST_IDLE);
    start_d = (state_d == ST_START);
    ok_d    = (state_d == ST_FLUSH) || (state_d == ST_ACK);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  assign ADDER_INITIATOR_Cmd_Ready                   = ready_q;
  assign ADDER_INITIATOR_Start_Routine               = start_q;
  assign ADDER_INITIATOR_Routine_Finished_Already_Ok = ok_q;
  assign ADDER_INITIATOR_Busy                        = busy_q;
  assign ADDER_INITIATOR_Done                        = done_q;
  assign ADDER_INITIATOR_Error_Timeout               = err_q;
  assign ADDER_INITIATOR_Aborted                     = aborted_q;
  assign ADDER_INITIATOR_Routines_Completed          = completed_q;

endmodule
